// File: rtl/aes_in_seq.sv
// aes_in_seq: feeds one {plaintext, key} block at a time into an AES core.
// A one-entry skid buffer accepts the next block while the current one is in
// flight. Each block produces a start pulse followed by four plaintext words
// and then four key words, least-significant word first. The sequencer then
// waits for the core's done pulse, giving up after DONE_TIMEOUT cycles.
//
// state | meaning
// IDLE  | no block in flight; a held block is popped on the next edge
// START | start pulse on the core, d_out = 0
// PT    | plaintext word wc on d_out
// KEY   | key word wc on d_out
// WAIT  | waiting for core done, tmo counts cycles spent here
module aes_in_seq #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         start,
  output logic [31:0]  d_out,
  input  logic         done,
  output logic         busy,
  output logic         err,
  output logic [15:0]  blk_cnt
);

  localparam int TMO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, PT, KEY, WAIT} state_t;

  state_t           state;
  logic             buf_full;
  logic [127:0]     buf_pt;
  logic [127:0]     buf_key;
  logic [127:0]     pt_r;
  logic [127:0]     key_r;
  logic [1:0]       wc;
  logic [1:0]       wc_nxt;
  logic [TMO_W-1:0] tmo;
  logic             push;
  logic             pop;

  assign in_ready = !buf_full;
  assign push     = in_valid && !buf_full;
  // pop only happens when full and push only when empty, so they never collide
  assign pop      = (state == IDLE) && buf_full;
  assign wc_nxt   = wc + 2'd1;

  // one-entry input buffer: capture on transfer, release when the FSM pops it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_full <= 1'b0;
      buf_pt   <= '0;
      buf_key  <= '0;
    end else if (push) begin
      buf_full <= 1'b1;
      buf_pt   <= in_pt;
      buf_key  <= in_key;
    end else if (pop) begin
      buf_full <= 1'b0;
    end
  end

  // sequencer with registered outputs computed from the state being entered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      pt_r    <= '0;
      key_r   <= '0;
      wc      <= '0;
      tmo     <= '0;
      blk_cnt <= '0;
      start   <= 1'b0;
      d_out   <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      start <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          d_out <= '0;
          if (buf_full) begin
            state <= START;
            pt_r  <= buf_pt;
            key_r <= buf_key;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        START: begin
          state <= PT;
          wc    <= '0;
          d_out <= pt_r[31:0];
        end
        PT: begin
          if (wc == 2'd3) begin
            state <= KEY;
            wc    <= '0;
            d_out <= key_r[31:0];
          end else begin
            wc    <= wc_nxt;
            d_out <= pt_r[{wc_nxt, 5'b0} +: 32];
          end
        end
        KEY: begin
          if (wc == 2'd3) begin
            state <= WAIT;
            wc    <= '0;
            tmo   <= '0;
            d_out <= '0;
          end else begin
            wc    <= wc_nxt;
            d_out <= key_r[{wc_nxt, 5'b0} +: 32];
          end
        end
        WAIT: begin
          // done on the terminal cycle wins over the timeout
          if (done) begin
            state   <= IDLE;
            busy    <= 1'b0;
            blk_cnt <= blk_cnt + 16'd1;
          end else if (tmo == TMO_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          d_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_in_seq.md
AES_IN_SEQ -- requirements
Module: aes_in_seq

Interface
REQ-001 Parameter: DONE_TIMEOUT, default 64, max cycles spent in WAIT for core done before abort.
REQ-002 CLK  input  1  single clock; all flops rising-edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream block offer.
REQ-005 in_ready  output  1  upstream block accept; transfer occurs when in_valid & in_ready at a rising edge.
REQ-006 in_pt  input  128  plaintext block.
REQ-007 in_key  input  128  cipher key.
REQ-008 start  output  1  one-cycle start pulse to AES core.
REQ-009 d_out  output  32  word bus to AES core d_in.
REQ-010 done  input  1  AES core completion pulse.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  one-cycle pulse on done timeout.
REQ-013 blk_cnt  output  16  count of blocks completed with done.

Function
REQ-014 Input buffer SHALL be one entry, {pt,key}; in_ready = !buf_full (combinational from the flop).
- Push and pop never occur in the same cycle.
REQ-015 FSM states SHALL be IDLE, START, PT, KEY, WAIT.
- Word counter wc is 2 bits.
REQ-016 IDLE: if buf_full -> START; pop buffer into working regs pt_r/key_r; clear buf_full.
REQ-017 START: start=1 for exactly this cycle; d_out=0 -> PT with wc=0.
REQ-018 PT: d_out = pt_r[32*wc+31 : 32*wc]; wc increments each cycle.
- At wc=3 -> KEY, wc=0.
- Word 0 SHALL be on d_out the cycle immediately after start.
REQ-019 KEY: d_out = key_r[32*wc+31 : 32*wc]; wc increments.
- At wc=3 -> WAIT, wc=0.
- Total: 1 start cycle + 8 word cycles, no gaps.
REQ-020 d_out SHALL be registered, driven by state/wc.
- It is 0 in IDLE and WAIT.
REQ-021 WAIT: timeout counter tmo starts at 0 and increments each cycle.
- done=1 -> IDLE; blk_cnt += 1, wrapping 0xFFFF -> 0x0000.
- tmo reaches DONE_TIMEOUT-1 with done=0 -> IDLE; err=1 for one cycle; blk_cnt unchanged.
REQ-022 done while not in WAIT SHALL be ignored: no count, no state change.
REQ-023 done on the same cycle as the timeout terminal count SHALL count as success; no err.
REQ-024 Buffer SHALL accept a new block while the FSM is in START/PT/KEY/WAIT.
- A held block starts on the cycle after return to IDLE: IDLE->START latency is 1 cycle.
REQ-025 in_pt/in_key SHALL only be sampled on transfer.
- Changes while not transferring have no effect.

Reset
REQ-026 RST_N low SHALL asynchronously force:
- FSM to IDLE; buf_full=0, wc=0, tmo=0, blk_cnt=0.
- start=0, d_out=0, err=0, busy=0.
- in_ready=1 (buffer empty, per REQ-014).
REQ-027 Reset mid-sequence SHALL discard buffered and in-flight blocks.
- No start or err pulse follows deassertion until a new transfer.
REQ-028 Reset deassertion is synchronised externally; first active edge after release behaves as IDLE.

Verification
REQ-029 Single block:
- Stimulus: pt=0x00112233_44556677_8899AABB_CCDDEEFF, key=0x00010203_04050607_08090A0B_0C0D0E0F; done pulsed 20 cycles after last key word.
- Response: start pulse, then d_out = CCDDEEFF, 8899AABB, 44556677, 00112233, 0C0D0E0F, 08090A0B, 04050607, 00010203 on consecutive cycles; blk_cnt=1; busy falls the cycle after done.
REQ-030 Back-to-back:
- Stimulus: second block offered during PT of first.
- Response: in_ready drops after accept; second start occurs 1 cycle after first done-return to IDLE; blk_cnt=2.
REQ-031 Timeout:
- Stimulus: DONE_TIMEOUT=8, done never asserted.
- Response: err pulses 8 cycles after entering WAIT; busy=0 next cycle; blk_cnt=0.
REQ-032 Boundaries:
- Stray done in IDLE/PT -> no count.
- done coincident with terminal tmo -> blk_cnt+1, err=0.
REQ-033 Reset mid-KEY:
- Stimulus: RST_N low during KEY word 2.
- Response: outputs zero immediately (async); no start after release; in_ready=1.
REQ-034 Wrap: preload via 65536 completions (or forced counter) -> blk_cnt wraps 0xFFFF -> 0x0000.
